// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store memory arbiter.
// The state and owner encodings are used by the top and by the winner-select logic.
package mem_arbiter_pkg;

  localparam int CNT_W       = 8;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    LSU   = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_sel.sv
// Combinational winner select between fetch and load-store requesters.
// With MEM_ARBITER_RR_EN defined, a tie goes to the requester not served last; otherwise load-store always wins.
module mem_arbiter_sel
  import mem_arbiter_pkg::*;
(
  input  logic   idle,
  input  logic   if_req,
  input  logic   mem_req,
`ifdef MEM_ARBITER_RR_EN
  input  owner_e last_owner,
`endif
  output logic   gnt_if,
  output logic   gnt_mem
);

  always_comb begin
    gnt_if  = 1'b0;
    gnt_mem = 1'b0;
    if (idle) begin
      if (if_req && mem_req) begin
`ifdef MEM_ARBITER_RR_EN
        if (last_owner == LSU) begin
          gnt_if = 1'b1;
        end else begin
          gnt_mem = 1'b1;
        end
`else
        gnt_mem = 1'b1;
`endif
      end else begin
        gnt_if  = if_req;
        gnt_mem = mem_req;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port data memory between instruction fetch and load-store.
// Define MEM_ARBITER_RR_EN for round-robin tie breaking; default build uses fixed load-store priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,

  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_gnt_o,
  output logic        mem_rvalid_o,
  output logic [31:0] mem_rdata_o,

  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_ready_i,
  input  logic [31:0] ram_rdata_i,

  output logic        err_o
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_e             state_q;
  owner_e             owner_q;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
`ifdef MEM_ARBITER_RR_EN
  owner_e             last_q;
`endif

  logic idle;
  logic gnt_if;
  logic gnt_mem;
  logic busy;
  logic resp;

  assign idle    = rst && (state_q == IDLE);
  assign cnt_nxt = cnt_q + CNT_W'(1);

  mem_arbiter_sel u_sel (
    .idle       (idle),
    .if_req     (if_req_i),
    .mem_req    (mem_req_i),
`ifdef MEM_ARBITER_RR_EN
    .last_owner (last_q),
`endif
    .gnt_if     (gnt_if),
    .gnt_mem    (gnt_mem)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= FETCH;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_q  <= FETCH;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_if || gnt_mem) begin
            state_q <= BUSY;
            owner_q <= gnt_mem ? LSU : FETCH;
            we_q    <= gnt_mem && mem_we_i;
            addr_q  <= gnt_mem ? mem_addr_i : if_addr_i;
            wdata_q <= gnt_mem ? mem_wdata_i : 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_q  <= gnt_mem ? LSU : FETCH;
`endif
          end
        end
        BUSY: begin
          // ready in the same cycle as the timeout still completes normally
          if (ram_ready_i) begin
            rdata_q <= we_q ? 32'd0 : ram_rdata_i;
            state_q <= RESP;
          end else if (cnt_nxt == TO_CNT) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q   <= cnt_nxt;
          end
        end
        RESP: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = rst && (state_q == BUSY);
  assign resp = rst && (state_q == RESP);

  assign if_gnt_o     = gnt_if;
  assign mem_gnt_o    = gnt_mem;

  assign if_rvalid_o  = resp && (owner_q == FETCH);
  assign mem_rvalid_o = resp && (owner_q == LSU);
  assign if_rdata_o   = if_rvalid_o  ? rdata_q : 32'd0;
  assign mem_rdata_o  = mem_rvalid_o ? rdata_q : 32'd0;
  assign err_o        = resp && err_q;

  assign ram_ce_o     = busy;
  assign ram_we_o     = busy && we_q;
  assign ram_addr_o   = busy ? addr_q  : 32'd0;
  assign ram_wdata_o  = busy ? wdata_q : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level timing model.
// Build with MEM_ARBITER_RR_EN defined to check the round-robin variant.
module tb_mem_arbiter;

  localparam int TO     = 15;
  localparam int NCYC   = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, mem_req_i, mem_we_i, ram_ready_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i, ram_rdata_i;
  logic        if_gnt_o, if_rvalid_o, mem_gnt_o, mem_rvalid_o;
  logic        ram_ce_o, ram_we_o, err_o;
  logic [31:0] if_rdata_o, mem_rdata_o, ram_addr_o, ram_wdata_o;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .mem_req_i    (mem_req_i),
    .mem_we_i     (mem_we_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .mem_gnt_o    (mem_gnt_o),
    .mem_rvalid_o (mem_rvalid_o),
    .mem_rdata_o  (mem_rdata_o),
    .ram_ce_o     (ram_ce_o),
    .ram_we_o     (ram_we_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_ready_i  (ram_ready_i),
    .ram_rdata_i  (ram_rdata_i),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int cyc;
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
  endtask

  // transaction model: grant cycle, planned ready delay, resulting response cycle
  bit          busy, t_own, t_we, t_err, last_lsu;
  int          t_start, t_resp, t_d;
  logic [31:0] t_addr, t_wdata, t_data, t_exp;
  bit          drop_if, drop_mem, did_force;
  bit          win_if, win_mem, in_busy, in_resp, rst_now;
  int          p, r;

  initial begin
    rst = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0;
    ram_ready_i = 1'b0; ram_rdata_i = '0;
    busy = 0; last_lsu = 0; drop_if = 0; drop_mem = 0; did_force = 0;
    t_start = 0; t_resp = 0; t_d = 0; t_own = 0; t_we = 0; t_err = 0;
    t_addr = '0; t_wdata = '0; t_data = '0; t_exp = '0;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk); #1;
      p = (cyc < 1000) ? 50 : (cyc < 2000) ? 100 : 20;

      if (drop_if)  begin if_req_i  = 1'b0; drop_if  = 0; end
      if (drop_mem) begin mem_req_i = 1'b0; drop_mem = 0; end
      if (!if_req_i) begin
        if_addr_i = $urandom;
        if ($urandom_range(99) < p) if_req_i = 1'b1;
      end
      if (!mem_req_i) begin
        mem_we_i    = 1'($urandom_range(1));
        mem_addr_i  = $urandom;
        mem_wdata_i = $urandom;
        if ($urandom_range(99) < p) mem_req_i = 1'b1;
      end

      rst_now = (cyc < 3) || ($urandom_range(199) == 0);
      if (!did_force && cyc > 300 && busy && cyc == t_start + 2) begin
        rst_now   = 1;
        did_force = 1;
      end
      rst = !rst_now;

      ram_rdata_i = $urandom;
      if (busy && cyc > t_start && cyc < t_resp) begin
        ram_ready_i = (cyc - t_start == t_d);
        if (ram_ready_i) ram_rdata_i = t_data;
      end else begin
        ram_ready_i = ($urandom_range(3) == 0);
      end

      @(negedge clk);
      win_if  = 0;
      win_mem = 0;
      if (!rst_now && !busy) begin
        if (if_req_i && mem_req_i) begin
`ifdef MEM_ARBITER_RR_EN
          win_mem = !last_lsu;
          win_if  = last_lsu;
`else
          win_mem = 1;
`endif
        end else begin
          win_if  = if_req_i;
          win_mem = mem_req_i;
        end
      end
      in_busy = !rst_now && busy && cyc > t_start && cyc < t_resp;
      in_resp = !rst_now && busy && cyc == t_resp;

      chk("if_gnt",     32'(if_gnt_o),     32'(win_if));
      chk("mem_gnt",    32'(mem_gnt_o),    32'(win_mem));
      chk("ram_ce",     32'(ram_ce_o),     32'(in_busy));
      chk("ram_we",     32'(ram_we_o),     32'(in_busy && t_we));
      chk("ram_addr",   ram_addr_o,        in_busy ? t_addr  : 32'd0);
      chk("ram_wdata",  ram_wdata_o,       in_busy ? t_wdata : 32'd0);
      chk("if_rvalid",  32'(if_rvalid_o),  32'(in_resp && !t_own));
      chk("if_rdata",   if_rdata_o,        (in_resp && !t_own) ? t_exp : 32'd0);
      chk("mem_rvalid", 32'(mem_rvalid_o), 32'(in_resp && t_own));
      chk("mem_rdata",  mem_rdata_o,       (in_resp && t_own) ? t_exp : 32'd0);
      chk("err",        32'(err_o),        32'(in_resp && t_err));

      if (rst_now) begin
        busy     = 0;
        last_lsu = 0;
      end else begin
        if (in_resp) busy = 0;
        if (win_if || win_mem) begin
          busy     = 1;
          t_start  = cyc;
          t_own    = win_mem;
          last_lsu = win_mem;
          t_we     = win_mem && mem_we_i;
          t_addr   = win_mem ? mem_addr_i  : if_addr_i;
          t_wdata  = win_mem ? mem_wdata_i : 32'd0;
          r        = int'($urandom_range(9));
          t_d      = (r < 4) ? 1 : (r < 8) ? int'($urandom_range(TO, 2)) : (r == 8) ? TO : TO + 1;
          t_data   = $urandom;
          t_err    = (t_d > TO);
          t_resp   = t_start + (t_err ? TO : t_d) + 1;
          t_exp    = (t_err || t_we) ? 32'd0 : t_data;
          if (win_if) drop_if = 1;
          else        drop_mem = 1;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
